// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B computed one bit per clock, LSB first,
// with a start/busy/done handshake and borrow/zero flags for compares.
module serial_subtractor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] diff_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             br_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             borrow_reg;
  logic             zero_reg;

  logic             d_next;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  // One full-subtractor cell; the result register fills from the MSB so the
  // first (LSB) difference bit lands in bit 0 after WIDTH shifts.
  always_comb begin
    d_next   = sa_reg[0] ^ sb_reg[0] ^ br_reg;
    br_next  = (~sa_reg[0] & sb_reg[0]) | (~(sa_reg[0] ^ sb_reg[0]) & br_reg);
    res_next = {d_next, res_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      sa_reg     <= '0;
      sb_reg     <= '0;
      res_reg    <= '0;
      diff_reg   <= '0;
      cnt_reg    <= '0;
      br_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      borrow_reg <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            sa_reg    <= a;
            sb_reg    <= b;
            res_reg   <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        SHIFT: begin
          res_reg <= res_next;
          sa_reg  <= sa_reg >> 1;
          sb_reg  <= sb_reg >> 1;
          br_reg  <= br_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          // Result outputs are only touched here, so they hold through IDLE
          // and across the next operation until it completes.
          if (cnt_reg == LAST_CNT) begin
            diff_reg   <= res_next;
            borrow_reg <= br_next;
            zero_reg   <= (res_next == '0);
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign diff       = diff_reg;
  assign borrow_out = borrow_reg;
  assign zero       = zero_reg;

endmodule
